// File: rtl/ahbl_gpio_irq.sv
// ahbl_gpio_irq - AHB-Lite GPIO block with edge-triggered interrupts.
//
// Purpose:
//   Memory-mapped GPIO with per-pin direction, atomic set/clear/toggle of the
//   output register, a multi-flop input synchroniser, and rising/falling
//   edge interrupt capture into a sticky, write-1-to-clear status register.
//   Zero wait-state slave.
//
// Ports:
//   HCLK, HRESET           clock, asynchronous active-high reset
//   HADDR..HWDATA          AHB-Lite slave inputs
//   HREADYOUT, HRDATA      AHB-Lite slave outputs (HREADYOUT always 1)
//   GPIO_IN  [WIDTH]       pad inputs (asynchronous to HCLK)
//   GPIO_OUT [WIDTH]       pad output values (registered)
//   GPIO_OE  [WIDTH]       pad output enables, 1 = drive (registered)
//   IRQ                    level interrupt request (registered)
//
// Register map (offset = HADDR[7:0]):
//   0x00 DATA_IN RO | 0x04 DATA_OUT RW | 0x08 DIR RW | 0x0C SET WO
//   0x10 CLR WO     | 0x14 TGL WO      | 0x18 IE RW  | 0x1C IRISE RW
//   0x20 IFALL RW   | 0x24 IS R/W1C    | others read 0xBADDBEEF
module ahbl_gpio_irq #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HREADY,
  input  logic [2:0]       HSIZE,
  input  logic             HWRITE,
  input  logic             HSEL,
  input  logic [31:0]      HWDATA,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH-1:0] GPIO_IN,
  output logic [WIDTH-1:0] GPIO_OUT,
  output logic [WIDTH-1:0] GPIO_OE,
  output logic             IRQ
);

  localparam logic [7:0] OFS_DIN   = 8'h00;
  localparam logic [7:0] OFS_DOUT  = 8'h04;
  localparam logic [7:0] OFS_DIR   = 8'h08;
  localparam logic [7:0] OFS_SET   = 8'h0C;
  localparam logic [7:0] OFS_CLR   = 8'h10;
  localparam logic [7:0] OFS_TGL   = 8'h14;
  localparam logic [7:0] OFS_IE    = 8'h18;
  localparam logic [7:0] OFS_IRISE = 8'h1C;
  localparam logic [7:0] OFS_IFALL = 8'h20;
  localparam logic [7:0] OFS_IS    = 8'h24;

  // Zero-extend a WIDTH-bit register value onto the 32-bit read bus.
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Address-phase capture
  logic [7:0]       haddr_r;
  logic [1:0]       htrans_r;
  logic             hwrite_r;
  logic             hsel_r;
  logic [2:0]       hsize_r;

  // Programmer-visible state
  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] ie_r;
  logic [WIDTH-1:0] irise_r;
  logic [WIDTH-1:0] ifall_r;
  logic [WIDTH-1:0] is_r;
  logic             irq_r;

  // Input path
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] data_in_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] event_s;

  // Next-state values
  logic             wr_en_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] data_out_s;
  logic [WIDTH-1:0] dir_s;
  logic [WIDTH-1:0] ie_s;
  logic [WIDTH-1:0] irise_s;
  logic [WIDTH-1:0] ifall_s;
  logic [WIDTH-1:0] w1c_s;
  logic [WIDTH-1:0] is_s;

  // Bits that carry no function here (upper address, size, data above WIDTH).
  logic unused_bits_s;
  assign unused_bits_s = ^{HADDR[31:8], hsize_r, htrans_r[0], HWDATA};

  assign HREADYOUT = 1'b1;
  assign GPIO_OUT  = data_out_r;
  assign GPIO_OE   = dir_r;
  assign IRQ       = irq_r;

  assign wr_en_s   = htrans_r[1] & hsel_r & hwrite_r;
  assign wdata_s   = HWDATA[WIDTH-1:0];
  assign data_in_s = sync_r[SYNC_STAGES-1];
  assign rise_s    = data_in_s & ~prev_r;
  assign fall_s    = ~data_in_s & prev_r;
  assign event_s   = (rise_s & irise_r) | (fall_s & ifall_r);

  // Capture address-phase controls whenever the bus advances.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      haddr_r  <= 8'h00;
      htrans_r <= 2'b00;
      hwrite_r <= 1'b0;
      hsel_r   <= 1'b0;
      hsize_r  <= 3'b000;
    end else if (HREADY) begin
      haddr_r  <= HADDR[7:0];
      htrans_r <= HTRANS;
      hwrite_r <= HWRITE;
      hsel_r   <= HSEL;
      hsize_r  <= HSIZE;
    end
  end

  // Register write decode for the data phase.
  always_comb begin
    data_out_s = data_out_r;
    dir_s      = dir_r;
    ie_s       = ie_r;
    irise_s    = irise_r;
    ifall_s    = ifall_r;
    w1c_s      = '0;
    if (wr_en_s) begin
      case (haddr_r)
        OFS_DOUT:  data_out_s = wdata_s;
        OFS_DIR:   dir_s      = wdata_s;
        OFS_SET:   data_out_s = data_out_r | wdata_s;
        OFS_CLR:   data_out_s = data_out_r & ~wdata_s;
        OFS_TGL:   data_out_s = data_out_r ^ wdata_s;
        OFS_IE:    ie_s       = wdata_s;
        OFS_IRISE: irise_s    = wdata_s;
        OFS_IFALL: ifall_s    = wdata_s;
        OFS_IS:    w1c_s      = wdata_s;
        default:   w1c_s      = '0;
      endcase
    end else begin
      w1c_s = '0;
    end
    // Clear first, then OR in new events, so a same-cycle event survives W1C.
    is_s = (is_r & ~w1c_s) | event_s;
  end

  // Programmer-visible register state and interrupt output.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      data_out_r <= '0;
      dir_r      <= '0;
      ie_r       <= '0;
      irise_r    <= '0;
      ifall_r    <= '0;
      is_r       <= '0;
      irq_r      <= 1'b0;
    end else begin
      data_out_r <= data_out_s;
      dir_r      <= dir_s;
      ie_r       <= ie_s;
      irise_r    <= irise_s;
      ifall_r    <= ifall_s;
      is_r       <= is_s;
      irq_r      <= |(is_r & ie_r);
    end
  end

  // Pad input synchroniser plus one-cycle history for edge detection.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
      prev_r <= '0;
    end else begin
      sync_r[0] <= GPIO_IN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= data_in_s;
    end
  end

  // Read mux driven from the registered address.
  always_comb begin
    case (haddr_r)
      OFS_DIN:   HRDATA = zext(data_in_s);
      OFS_DOUT:  HRDATA = zext(data_out_r);
      OFS_DIR:   HRDATA = zext(dir_r);
      OFS_SET:   HRDATA = 32'h0000_0000;
      OFS_CLR:   HRDATA = 32'h0000_0000;
      OFS_TGL:   HRDATA = 32'h0000_0000;
      OFS_IE:    HRDATA = zext(ie_r);
      OFS_IRISE: HRDATA = zext(irise_r);
      OFS_IFALL: HRDATA = zext(ifall_r);
      OFS_IS:    HRDATA = zext(is_r);
      default:   HRDATA = 32'hBADD_BEEF;
    endcase
  end

endmodule

// File: tb/tb_ahbl_gpio_irq.sv
// tb_ahbl_gpio_irq - directed self-checking bench for ahbl_gpio_irq.
// Two instances share one bus: a 32-pin default and an 8-pin variant.
module tb_ahbl_gpio_irq;

  logic        HCLK;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HWDATA;

  logic        hreadyout;
  logic [31:0] hrdata;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  logic        hreadyout8;
  logic [31:0] hrdata8;
  logic [7:0]  gpio_out8;
  logic [7:0]  gpio_oe8;
  logic        irq8;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;
  logic [31:0] rd8;

  ahbl_gpio_irq #(.WIDTH(32), .SYNC_STAGES(2)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .HSIZE(HSIZE), .HWRITE(HWRITE), .HSEL(HSEL),
    .HWDATA(HWDATA), .HREADYOUT(hreadyout), .HRDATA(hrdata),
    .GPIO_IN(gpio_in), .GPIO_OUT(gpio_out), .GPIO_OE(gpio_oe), .IRQ(irq)
  );

  ahbl_gpio_irq #(.WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .HSIZE(HSIZE), .HWRITE(HWRITE), .HSEL(HSEL),
    .HWDATA(HWDATA), .HREADYOUT(hreadyout8), .HRDATA(hrdata8),
    .GPIO_IN(gpio_in[7:0]), .GPIO_OUT(gpio_out8), .GPIO_OE(gpio_oe8), .IRQ(irq8)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic w);
    HADDR  = a;
    HTRANS = 2'b10;
    HWRITE = w;
    HSEL   = 1'b1;
  endtask

  task automatic bus_idle();
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSEL   = 1'b0;
  endtask

  // Returns after the data-phase edge, so the write has taken effect.
  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    addr_ph(a, 1'b1);
    cyc();
    bus_idle();
    HWDATA = d;
    cyc();
  endtask

  // Samples HRDATA of both instances during the data phase.
  task automatic ahb_read(input logic [31:0] a, output logic [31:0] r, output logic [31:0] r8);
    addr_ph(a, 1'b0);
    cyc();
    bus_idle();
    r  = hrdata;
    r8 = hrdata8;
  endtask

  initial begin
    HRESET = 1'b0;
    HADDR  = 32'h0;
    HTRANS = 2'b00;
    HREADY = 1'b1;
    HSIZE  = 3'b010;
    HWRITE = 1'b0;
    HSEL   = 1'b0;
    HWDATA = 32'h0;
    gpio_in = 32'hFFFF_FFFF;
    #2 HRESET = 1'b1;
    #1;
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_gpio_oe", gpio_oe, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_irq8", {31'h0, irq8}, 32'h0);
    check("hreadyout", {31'h0, hreadyout}, 32'h1);
    check("hreadyout8", {31'h0, hreadyout8}, 32'h1);
    cycles(3);
    HRESET = 1'b0;

    // Pins high at release with IRISE/IFALL=0: nothing latched.
    cycles(5);
    ahb_read(32'h24, rd, rd8);
    check("is_after_rel", rd, 32'h0);
    ahb_read(32'h00, rd, rd8);
    check("data_in_high", rd, 32'hFFFF_FFFF);
    check("data_in8_high", rd8, 32'h0000_00FF);
    gpio_in = 32'h0;
    cycles(5);
    ahb_read(32'h24, rd, rd8);
    check("is_after_fall", rd, 32'h0);
    check("irq_quiet", {31'h0, irq}, 32'h0);

    // DATA_OUT and set/clear/toggle.
    ahb_write(32'h04, 32'h0000_00F0);
    ahb_write(32'h0C, 32'h0000_0003);
    ahb_write(32'h10, 32'h0000_0010);
    ahb_write(32'h14, 32'h0000_0100);
    check("gpio_out_sct", gpio_out, 32'h0000_01E3);
    check("gpio_out8_sct", {24'h0, gpio_out8}, 32'h0000_00E3);
    ahb_read(32'h04, rd, rd8);
    check("rd_dout", rd, 32'h0000_01E3);
    check("rd8_dout", rd8, 32'h0000_00E3);
    ahb_read(32'h0C, rd, rd8);
    check("rd_set_wo", rd, 32'h0);

    // DIR width masking and unmapped read.
    ahb_write(32'h08, 32'hFFFF_FFFF);
    check("gpio_oe8", {24'h0, gpio_oe8}, 32'h0000_00FF);
    check("gpio_oe", gpio_oe, 32'hFFFF_FFFF);
    ahb_read(32'h08, rd, rd8);
    check("rd8_dir", rd8, 32'h0000_00FF);
    ahb_read(32'h40, rd, rd8);
    check("rd_unmapped", rd, 32'hBADD_BEEF);
    check("rd8_unmapped", rd8, 32'hBADD_BEEF);
    ahb_write(32'h00, 32'h1234_5678);
    ahb_read(32'h00, rd, rd8);
    check("din_ro", rd, 32'h0);

    // Back-to-back write then read of the same register.
    addr_ph(32'h18, 1'b1);
    cyc();
    HWDATA = 32'h0000_0005;
    addr_ph(32'h18, 1'b0);
    cyc();
    bus_idle();
    check("b2b_ie", hrdata, 32'h0000_0005);
    ahb_write(32'h18, 32'h0);

    // Rising edge on bit 0 with IE set.
    ahb_write(32'h1C, 32'h1);
    ahb_write(32'h18, 32'h1);
    gpio_in[0] = 1'b1;
    cycles(2);
    check("irq_early", {31'h0, irq}, 32'h0);
    addr_ph(32'h24, 1'b0);
    cyc();
    bus_idle();
    check("is_rise_timing", hrdata, 32'h1);
    check("irq_not_yet", {31'h0, irq}, 32'h0);
    cyc();
    check("irq_rise", {31'h0, irq}, 32'h1);
    ahb_write(32'h24, 32'h1);
    check("irq_lag_w1c", {31'h0, irq}, 32'h1);
    cyc();
    check("irq_cleared", {31'h0, irq}, 32'h0);
    ahb_read(32'h24, rd, rd8);
    check("is_cleared", rd, 32'h0);
    gpio_in[0] = 1'b0;
    cycles(4);

    // Falling edge on bit 1, IE masked then enabled.
    ahb_write(32'h1C, 32'h0);
    ahb_write(32'h20, 32'h2);
    ahb_write(32'h18, 32'h0);
    gpio_in[1] = 1'b1;
    cycles(4);
    gpio_in[1] = 1'b0;
    cycles(4);
    ahb_read(32'h24, rd, rd8);
    check("is_fall", rd, 32'h2);
    check("irq_masked", {31'h0, irq}, 32'h0);
    ahb_write(32'h18, 32'h2);
    ahb_read(32'h24, rd, rd8);
    check("is_kept_ie", rd, 32'h2);
    check("irq_fall", {31'h0, irq}, 32'h1);
    ahb_write(32'h24, 32'h2);
    cycles(2);
    check("irq_fall_clr", {31'h0, irq}, 32'h0);

    // W1C coinciding with a new rising edge: set wins.
    ahb_write(32'h1C, 32'h1);
    ahb_write(32'h18, 32'h1);
    gpio_in[0] = 1'b1;
    cycles(5);
    check("irq_pre_race", {31'h0, irq}, 32'h1);
    gpio_in[0] = 1'b0;
    cycles(4);
    gpio_in[0] = 1'b1;
    cyc();
    ahb_write(32'h24, 32'h1);
    check("irq_race0", {31'h0, irq}, 32'h1);
    cyc();
    check("irq_race1", {31'h0, irq}, 32'h1);
    ahb_read(32'h24, rd, rd8);
    check("is_race", rd, 32'h1);

    // Reset during the data phase of a write.
    addr_ph(32'h04, 1'b1);
    cyc();
    bus_idle();
    HWDATA = 32'hFFFF_FFFF;
    HRESET = 1'b1;
    #1;
    check("gpio_out_async_rst", gpio_out, 32'h0);
    check("irq_async_rst", {31'h0, irq}, 32'h0);
    cyc();
    HRESET = 1'b0;
    cycles(2);
    check("gpio_out_post_rst", gpio_out, 32'h0);
    ahb_read(32'h04, rd, rd8);
    check("rd_dout_post_rst", rd, 32'h0);
    ahb_write(32'h04, 32'h0000_0055);
    check("gpio_out_first_wr", gpio_out, 32'h0000_0055);
    ahb_read(32'h04, rd, rd8);
    check("rd_first_wr", rd, 32'h0000_0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
